// File: rtl/flit_uart_tx.sv
// -----------------------------------------------------------------------------
// flit_uart_tx
//
// Transmit end of the flit link. Takes one 128-bit flit at a time from the
// router side. It replaces the version, flit_id and checksum fields with
// locally generated values and checks HEAD/BODY/TAIL framing. It then sends
// the flit to the UART transmitter as 16 bytes, MSB byte first, over a
// valid/ready handshake.
//
// Flit layout (MSB..LSB):
//   [127:124] version   [123:120] flittype   [119:112] flit_id
//   [111:16]  data      [15:0]    checksum
//
// Parameters
//   VERSION   value written into the version field of every transmitted flit
//   ID_INIT   flit_id given to the first flit sent after reset
//
// Ports
//   clk        in   1    system clock
//   rst        in   1    asynchronous, active-high reset
//   in_flit    in   128  flit from upstream (version/flit_id/checksum ignored)
//   in_valid   in   1    in_flit valid
//   in_ready   out  1    block can accept a flit (only while idle)
//   tx_data    out  8    byte to UART tx
//   tx_valid   out  1    tx_data valid
//   tx_ready   in   1    UART tx accepts byte
//   busy       out  1    a flit is being serialised
//   err_seq    out  1    one-cycle pulse: framing violation
//   err_type   out  1    one-cycle pulse: flittype is not HEAD/BODY/TAIL
// -----------------------------------------------------------------------------
module flit_uart_tx #(
   parameter logic [3:0] VERSION = 4'd1,
   parameter logic [7:0] ID_INIT = 8'd0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] in_flit,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [7:0]   tx_data,
   output logic         tx_valid,
   input  logic         tx_ready,
   output logic         busy,
   output logic         err_seq,
   output logic         err_type
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   localparam logic [3:0] FT_HEAD = 4'd0;
   localparam logic [3:0] FT_BODY = 4'd1;
   localparam logic [3:0] FT_TAIL = 4'd2;

   localparam logic [3:0] LAST_IDX = 4'd15;

   // One's-complement style checksum: 16-bit sum of the seven header/data
   // words, inverted.
   function automatic logic [15:0] calc_checksum(input logic [111:0] hdr);
      logic [15:0] sum;
      sum = '0;
      for (int w = 0; w < 7; w++) begin
         sum = sum + hdr[16*w +: 16];
      end
      return ~sum;
   endfunction

   logic [0:0]   state;
   logic [3:0]   idx;
   logic [7:0]   next_id;
   logic         in_packet;
   logic [127:0] frame;

   // Incoming field views
   logic [3:0]   in_type;
   logic [95:0]  in_data;
   logic         type_head;
   logic         type_body;
   logic         type_tail;
   logic         type_ok;

   // Accept classification
   logic         accept;
   logic         drop_type;
   logic         drop_seq;
   logic         do_tx;
   logic         head_trunc;

   logic [111:0] hdr_nxt;
   logic [127:0] frame_nxt;
   logic         tx_hs;

   // The upstream copies of these fields are overwritten here.
   logic         unused_in_fields;
   assign unused_in_fields = ^{in_flit[127:124], in_flit[119:112], in_flit[15:0]};

   assign in_type   = in_flit[123:120];
   assign in_data   = in_flit[111:16];
   assign type_head = (in_type == FT_HEAD);
   assign type_body = (in_type == FT_BODY);
   assign type_tail = (in_type == FT_TAIL);
   assign type_ok   = type_head | type_body | type_tail;

   // in_ready depends only on state, so accept never forms a
   // combinational loop through in_valid.
   assign in_ready = (state == ST_IDLE);
   assign busy     = (state == ST_SEND);
   assign tx_valid = (state == ST_SEND);

   assign accept     = in_ready & in_valid;
   assign drop_type  = accept & ~type_ok;
   // BODY/TAIL with no open packet carries no context and is discarded.
   assign drop_seq   = accept & type_ok & ~type_head & ~in_packet;
   assign do_tx      = accept & type_ok & (type_head | in_packet);
   // A HEAD inside an open packet is still sent. The packet it cuts short
   // is flagged.
   assign head_trunc = do_tx & type_head & in_packet;

   assign hdr_nxt   = {VERSION, in_type, next_id, in_data};
   assign frame_nxt = {hdr_nxt, calc_checksum(hdr_nxt)};

   assign tx_hs = tx_valid & tx_ready;

   // Frame is a shift register. The byte on the wire is always the top byte,
   // so tx_data holds its value until the handshake shifts it out.
   assign tx_data = frame[127:120];

   // ---- control: state, byte index, id sequence, packet tracking, errors ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         idx       <= '0;
         next_id   <= ID_INIT;
         in_packet <= 1'b0;
         err_seq   <= 1'b0;
         err_type  <= 1'b0;
      end else begin
         err_seq  <= drop_seq | head_trunc;
         err_type <= drop_type;

         case (state)
            ST_IDLE: begin
               if (do_tx) begin
                  state   <= ST_SEND;
                  idx     <= '0;
                  next_id <= next_id + 8'd1;
                  if (type_head) begin
                     in_packet <= 1'b1;
                  end else if (type_tail) begin
                     in_packet <= 1'b0;
                  end
               end
            end
            ST_SEND: begin
               if (tx_hs) begin
                  idx <= idx + 4'd1;
                  if (idx == LAST_IDX) begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // ---- data: frame load on accept, shift one byte per handshake ----
   // Cleared on reset so tx_data reads zero out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame <= '0;
      end else if (do_tx) begin
         frame <= frame_nxt;
      end else if (tx_hs) begin
         frame <= {frame[119:0], 8'h00};
      end
   end

endmodule

// File: tb/tb_flit_uart_tx.sv
module tb_flit_uart_tx;

   localparam logic [3:0] VER     = 4'd1;
   localparam logic [7:0] ID0     = 8'd0;
   localparam logic [3:0] FT_HEAD = 4'd0;
   localparam logic [3:0] FT_BODY = 4'd1;
   localparam logic [3:0] FT_TAIL = 4'd2;

   logic         clk;
   logic         rst;
   logic [127:0] in_flit;
   logic         in_valid;
   logic         in_ready;
   logic [7:0]   tx_data;
   logic         tx_valid;
   logic         tx_ready;
   logic         busy;
   logic         err_seq;
   logic         err_type;

   int total;
   int bad;

   flit_uart_tx #(.VERSION(VER), .ID_INIT(ID0)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_flit  (in_flit),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .busy     (busy),
      .err_seq  (err_seq),
      .err_type (err_type)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference frame: header with substituted fields, then inverted 16-bit word sum.
   function automatic logic [127:0] exp_frame(input logic [3:0] ft, input logic [7:0] id,
                                              input logic [95:0] d);
      logic [111:0] h;
      logic [31:0]  s;
      h = {VER, ft, id, d};
      s = 32'd0;
      for (int i = 0; i < 7; i++) s = s + {16'd0, h[16*i +: 16]};
      return {h, ~s[15:0]};
   endfunction

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; in_flit = '0; tx_ready = 1'b0;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 ||
          err_seq !== 1'b0 || err_type !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: got in_ready=%b tx_valid=%b tx_data=%h busy=%b err_seq=%b err_type=%b, want 1 0 00 0 0 0",
                  in_ready, tx_valid, tx_data, busy, err_seq, err_type);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Present one flit for a single cycle (caller is at a negedge) and check the
   // cycle after accept. Junk goes into version/id/checksum to prove they are replaced.
   task automatic send(input logic [3:0] ft, input logic [95:0] d, input logic exp_tx,
                       input logic exp_seq, input logic exp_type);
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL send_ready: in_ready=%b want 1", in_ready);
      end
      in_flit  = {4'hA, ft, 8'h5C, d, 16'h1234};
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_flit  = '0;
      total++;
      if (tx_valid !== exp_tx || err_seq !== exp_seq || err_type !== exp_type) begin
         bad++;
         $display("FAIL accept_effect type=%h: got tx_valid=%b err_seq=%b err_type=%b, want %b %b %b",
                  ft, tx_valid, err_seq, err_type, exp_tx, exp_seq, exp_type);
      end
      if (!exp_tx) begin
         @(negedge clk);
         total++;
         if (err_seq !== 1'b0 || err_type !== 1'b0 || tx_valid !== 1'b0) begin
            bad++;
            $display("FAIL err_one_pulse: got err_seq=%b err_type=%b tx_valid=%b, want 0 0 0",
                     err_seq, err_type, tx_valid);
         end
      end
   endtask

   // Receive nbytes of a frame. mode 0: tx_ready=1; mode 1: ready toggles, starting low.
   task automatic collect(input logic [127:0] exp, input int nbytes, input int mode,
                          output int busy_cycles);
      int          idx;
      int          cyc;
      logic        rdy;
      logic        stalled;
      logic [7:0]  held;
      logic [7:0]  want;
      idx = 0; cyc = 0; stalled = 1'b0; held = 8'h00; busy_cycles = 0;
      while (idx < nbytes && cyc < 400) begin
         rdy = (mode == 0) ? 1'b1 : cyc[0];
         if (busy === 1'b1) busy_cycles++;
         total++;
         if (tx_valid !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL send_flags byte%0d: got tx_valid=%b in_ready=%b, want 1 0",
                     idx, tx_valid, in_ready);
         end
         if (cyc > 0) begin
            total++;
            if (err_seq !== 1'b0 || err_type !== 1'b0) begin
               bad++;
               $display("FAIL err_during_send byte%0d: got err_seq=%b err_type=%b, want 0 0",
                        idx, err_seq, err_type);
            end
         end
         if (stalled) begin
            total++;
            if (tx_data !== held) begin
               bad++;
               $display("FAIL stall_stable byte%0d: got %h want %h", idx, tx_data, held);
            end
         end
         tx_ready = rdy;
         if (tx_valid === 1'b1 && rdy) begin
            want = exp[127 - 8*idx -: 8];
            total++;
            if (tx_data !== want) begin
               bad++;
               $display("FAIL byte%0d: got %h want %h", idx, tx_data, want);
            end
            idx++;
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            held    = tx_data;
         end
         cyc++;
         @(negedge clk);
      end
      if (idx < nbytes) begin
         total++;
         bad++;
         $display("FAIL collect_timeout: got %0d bytes want %0d", idx, nbytes);
      end
   endtask

   task automatic check_idle(input string tag);
      total++;
      if (tx_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL idle_%s: got tx_valid=%b in_ready=%b busy=%b, want 0 1 0",
                  tag, tx_valid, in_ready, busy);
      end
   endtask

   task automatic test_reset();
      do_reset();
   endtask

   task automatic test_single_head();
      int bc;
      do_reset();
      send(FT_HEAD, 96'h0, 1'b1, 1'b0, 1'b0);
      // Hand-computed: words 0x1000 + six zeros, inverted -> 0xEFFF.
      collect(128'h1000_0000_0000_0000_0000_0000_0000_EFFF, 16, 0, bc);
      total++;
      if (bc != 16) begin
         bad++;
         $display("FAIL busy_cycles: got %0d want 16", bc);
      end
      check_idle("after_head");
   endtask

   task automatic test_back_to_back();
      int bc;
      logic [95:0] d0, d1, d2;
      d0 = 96'h0123_4567_89AB_CDEF_FEDC_BA98;
      d1 = 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
      d2 = 96'h8000_0001_7FFF_0000_1234_5678;
      do_reset();
      send(FT_HEAD, d0, 1'b1, 1'b0, 1'b0);
      collect(exp_frame(FT_HEAD, 8'd0, d0), 16, 1, bc);
      send(FT_BODY, d1, 1'b1, 1'b0, 1'b0);
      collect(exp_frame(FT_BODY, 8'd1, d1), 16, 1, bc);
      send(FT_TAIL, d2, 1'b1, 1'b0, 1'b0);
      collect(exp_frame(FT_TAIL, 8'd2, d2), 16, 1, bc);
      check_idle("after_b2b");
   endtask

   task automatic test_seq_error();
      int bc;
      do_reset();
      send(FT_BODY, 96'h55, 1'b0, 1'b1, 1'b0);
      send(FT_TAIL, 96'h66, 1'b0, 1'b1, 1'b0);
      send(FT_HEAD, 96'h77, 1'b1, 1'b0, 1'b0);
      collect(exp_frame(FT_HEAD, 8'd0, 96'h77), 16, 0, bc);
      check_idle("after_seq");
   endtask

   task automatic test_type_error();
      int bc;
      do_reset();
      send(4'hF, 96'h1, 1'b0, 1'b0, 1'b1);
      send(4'h3, 96'h2, 1'b0, 1'b0, 1'b1);
      send(FT_HEAD, 96'hAB, 1'b1, 1'b0, 1'b0);
      collect(exp_frame(FT_HEAD, 8'd0, 96'hAB), 16, 0, bc);
      // Second HEAD while the packet is open: sent with err_seq.
      send(FT_HEAD, 96'hCD, 1'b1, 1'b1, 1'b0);
      collect(exp_frame(FT_HEAD, 8'd1, 96'hCD), 16, 0, bc);
      check_idle("after_type");
   endtask

   task automatic test_id_wrap();
      int bc;
      logic [31:0] iv;
      logic [3:0]  ft;
      do_reset();
      for (int i = 0; i < 257; i++) begin
         iv = i;
         ft = iv[0] ? FT_TAIL : FT_HEAD;
         send(ft, {64'hA5A5_5A5A_0F0F_F0F0, iv}, 1'b1, 1'b0, 1'b0);
         collect(exp_frame(ft, iv[7:0], {64'hA5A5_5A5A_0F0F_F0F0, iv}), 16, 0, bc);
      end
      check_idle("after_wrap");
   endtask

   task automatic test_reset_mid_send();
      int bc;
      do_reset();
      send(FT_HEAD, 96'h11, 1'b1, 1'b0, 1'b0);
      collect(exp_frame(FT_HEAD, 8'd0, 96'h11), 16, 0, bc);
      send(FT_TAIL, 96'h22, 1'b1, 1'b0, 1'b0);
      collect(exp_frame(FT_TAIL, 8'd1, 96'h22), 7, 0, bc);
      rst = 1'b1;
      #1;
      total++;
      if (tx_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || tx_data !== 8'h00) begin
         bad++;
         $display("FAIL async_reset: got tx_valid=%b busy=%b in_ready=%b tx_data=%h, want 0 0 1 00",
                  tx_valid, busy, in_ready, tx_data);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_idle("after_rst");
      // in_packet cleared: a HEAD starts a fresh packet with id restarted.
      send(FT_HEAD, 96'h33, 1'b1, 1'b0, 1'b0);
      collect(exp_frame(FT_HEAD, ID0, 96'h33), 16, 0, bc);
      check_idle("after_restart");
   endtask

   initial begin
      total = 0; bad = 0;
      rst = 1'b1; in_valid = 1'b0; in_flit = '0; tx_ready = 1'b0;
      test_reset();
      test_single_head();
      test_back_to_back();
      test_seq_error();
      test_type_error();
      test_id_wrap();
      test_reset_mid_send();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
